// File: rtl/crc8_pkg.sv
// Shared CRC-8 framing definitions: FSM encoding, default polynomial/seed
// and the single-bit LFSR step used by both the LFSR and the CRC snapshot.
package crc8_pkg;

    localparam int unsigned CRC_W = 8;
    localparam int unsigned CNT_W = 3;

    localparam logic [CRC_W-1:0] DEFAULT_POLY = 8'h07;
    localparam logic [CRC_W-1:0] DEFAULT_INIT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_GAP  = 2'd2,
        ST_CRC  = 2'd3
    } state_e;

    // One MSB-first shift of the CRC register with the incoming serial bit.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             b,
                                                   input logic [CRC_W-1:0] poly);
        logic fb;
        fb = b ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : CRC_W'(0));
    endfunction

endpackage

// File: rtl/crc8_frame_controller_if.sv
// Byte-in / bit-out handshake bundle of the CRC-8 frame controller.
interface crc8_frame_controller_if;

    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output in_data, in_last, in_valid, tx_ready,
        input  in_ready, tx_bit, tx_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, tx_ready,
        output in_ready, tx_bit, tx_valid
    );

endinterface

// File: rtl/crc8_serial_lfsr.sv
// Bit-serial CRC-8 register: synchronous load of the seed, one shift per enabled cycle.
module crc8_serial_lfsr
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY,
    parameter logic [CRC_W-1:0] INIT = DEFAULT_INIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CRC_W-1:0] init,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    // Load wins over shift so a frame start always begins from the seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= INIT;
        end else if (load) begin
            crc <= init;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in, POLY);
        end
    end

endmodule

// File: rtl/crc8_frame_controller.sv
// Serialises payload bytes MSB first and appends the running CRC-8 of the frame.
module crc8_frame_controller
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY,
    parameter logic [CRC_W-1:0] INIT = DEFAULT_INIT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    crc8_frame_controller_if.slave  bus,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [CRC_W-1:0]        crc_out
);

    state_e             state, state_nxt;
    logic [7:0]         byte_q, byte_nxt;
    logic               last_q, last_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [CRC_W-1:0]   crc_sr, crc_sr_nxt;
    logic [CRC_W-1:0]   crc_out_nxt;
    logic               done_nxt;

    logic               lfsr_load;
    logic               lfsr_en;
    logic [CRC_W-1:0]   lfsr_crc;

    logic               tx_bit_c;
    logic               tx_valid_c;
    logic               in_ready_c;

    crc8_serial_lfsr #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .init    (INIT),
        .en      (lfsr_en),
        .bit_in  (tx_bit_c),
        .crc     (lfsr_crc)
    );

    // Next-state, datapath and handshake decode; abort overrides everything at the end.
    always_comb begin
        state_nxt   = state;
        byte_nxt    = byte_q;
        last_nxt    = last_q;
        bit_cnt_nxt = bit_cnt;
        crc_sr_nxt  = crc_sr;
        crc_out_nxt = crc_out;
        done_nxt    = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;
        tx_valid_c  = 1'b0;
        tx_bit_c    = 1'b0;
        in_ready_c  = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && !abort) begin
                    byte_nxt    = bus.in_data;
                    last_nxt    = bus.in_last;
                    bit_cnt_nxt = CNT_W'(7);
                    lfsr_load   = 1'b1;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid_c = 1'b1;
                tx_bit_c   = byte_q[bit_cnt];
                in_ready_c = (bit_cnt == CNT_W'(0)) && bus.tx_ready && !last_q;
                if (bus.tx_ready && !abort) begin
                    lfsr_en     = 1'b1;
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(0)) begin
                        if (last_q) begin
                            // CRC must include the bit being shifted this very cycle.
                            crc_sr_nxt  = crc8_step(lfsr_crc, tx_bit_c, POLY);
                            bit_cnt_nxt = CNT_W'(7);
                            state_nxt   = ST_CRC;
                        end else if (bus.in_valid) begin
                            byte_nxt    = bus.in_data;
                            last_nxt    = bus.in_last;
                            bit_cnt_nxt = CNT_W'(7);
                        end else begin
                            state_nxt   = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && !abort) begin
                    byte_nxt    = bus.in_data;
                    last_nxt    = bus.in_last;
                    bit_cnt_nxt = CNT_W'(7);
                    state_nxt   = ST_DATA;
                end
            end
            ST_CRC: begin
                tx_valid_c = 1'b1;
                tx_bit_c   = crc_sr[bit_cnt];
                if (bus.tx_ready && !abort) begin
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(0)) begin
                        crc_out_nxt = crc_sr;
                        done_nxt    = 1'b1;
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort) begin
            in_ready_c = 1'b0;
            state_nxt  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            bit_cnt <= CNT_W'(0);
            crc_sr  <= CRC_W'(0);
            crc_out <= CRC_W'(0);
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            byte_q  <= byte_nxt;
            last_q  <= last_nxt;
            bit_cnt <= bit_cnt_nxt;
            crc_sr  <= crc_sr_nxt;
            crc_out <= crc_out_nxt;
            done    <= done_nxt;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.tx_valid = tx_valid_c;
    assign bus.tx_bit   = tx_bit_c;
    assign busy         = (state != ST_IDLE);

endmodule
